// File: rtl/cordic_batch_sequencer.sv
// Batch sequencer for the inner-cosine / fp-accumulator datapath.
// Accepts a batch command, streams samples into the pipeline under a shared
// clock-enable, tags the first and last sample through delay lines matched
// to the datapath latency, and returns the accumulated sum with sticky flags.
module cordic_batch_sequencer #(
  parameter int unsigned INNER_LAT = 43,
  parameter int unsigned ACC_LAT   = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             pipe_en,
  output logic [31:0]      pipe_dataa,
  output logic             acc_n,
  input  logic [31:0]      acc_result,
  input  logic             acc_xo,
  input  logic             acc_xu,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [1:0]       res_flags,
  output logic             busy
);

  localparam int unsigned LAST_LAT = INNER_LAT + ACC_LAT;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]    remaining;
  logic                first_pending;
  logic [INNER_LAT-1:0] first_line;
  logic [LAST_LAT-1:0]  last_line;
  logic                acc_seen;
  logic                sticky_xo;
  logic                sticky_xu;

  logic cmd_fire;
  logic issue;
  logic last_issue;
  logic capture;
  logic flag_window;

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign issue       = in_valid && in_ready;
  assign last_issue  = issue && (remaining == CNT_W'(1));
  assign capture     = (state == DRAIN) && last_line[LAST_LAT-1];
  assign flag_window = ((state == FEED) || (state == DRAIN)) && acc_seen;

  assign pipe_dataa = in_data;
  assign acc_n      = first_line[INNER_LAT-1];
  assign busy       = (state != IDLE);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode plus handshake readies and the shared clock-enable
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    pipe_en    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = (cmd_count == '0) ? HOLD : FEED;
      end
      FEED: begin
        in_ready = 1'b1;
        pipe_en  = in_valid;
        if (in_valid && (remaining == CNT_W'(1))) state_next = DRAIN;
      end
      DRAIN: begin
        pipe_en = 1'b1;
        if (last_line[LAST_LAT-1]) state_next = HOLD;
      end
      HOLD: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Batch counter, tag delay lines, sticky flags and the result register
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining     <= '0;
      first_pending <= 1'b0;
      first_line    <= '0;
      last_line     <= '0;
      acc_seen      <= 1'b0;
      sticky_xo     <= 1'b0;
      sticky_xu     <= 1'b0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_flags     <= '0;
    end else begin
      if (cmd_fire) begin
        remaining     <= cmd_count;
        first_pending <= 1'b1;
        acc_seen      <= 1'b0;
        sticky_xo     <= 1'b0;
        sticky_xu     <= 1'b0;
      end else begin
        if (issue) begin
          remaining     <= remaining - CNT_W'(1);
          first_pending <= 1'b0;
        end
        if (flag_window) begin
          sticky_xo <= sticky_xo | acc_xo;
          sticky_xu <= sticky_xu | acc_xu;
        end
        if (pipe_en && acc_n) acc_seen <= 1'b1;
      end

      // Tags advance only with the datapath so stalls keep them aligned
      if (pipe_en) begin
        first_line <= {first_line[INNER_LAT-2:0], issue && first_pending};
        last_line  <= {last_line[LAST_LAT-2:0], last_issue};
      end

      // Capture also flushes the tag lines; HOLD freezes them otherwise
      if (capture) begin
        res_valid  <= 1'b1;
        res_data   <= acc_result;
        res_flags  <= {sticky_xo | (flag_window & acc_xo),
                       sticky_xu | (flag_window & acc_xu)};
        first_line <= '0;
        last_line  <= '0;
      end else if (cmd_fire && (cmd_count == '0)) begin
        res_valid <= 1'b1;
        res_data  <= '0;
        res_flags <= '0;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_batch_sequencer.sv
// Directed bench for cordic_batch_sequencer with a behavioural datapath:
// inner function = pure enabled-edge delay, accumulator = delayed running sum.
module tb_cordic_batch_sequencer;

  localparam int unsigned INNER_LAT = 43;
  localparam int unsigned ACC_LAT   = 8;
  localparam int unsigned CNT_W     = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             pipe_en;
  logic [31:0]      pipe_dataa;
  logic             acc_n;
  logic [31:0]      acc_result;
  logic             acc_xo = 1'b0;
  logic             acc_xu = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_data;
  logic [1:0]       res_flags;
  logic             busy;

  cordic_batch_sequencer #(
    .INNER_LAT(INNER_LAT),
    .ACC_LAT  (ACC_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .pipe_en   (pipe_en),
    .pipe_dataa(pipe_dataa),
    .acc_n     (acc_n),
    .acc_result(acc_result),
    .acc_xo    (acc_xo),
    .acc_xu    (acc_xu),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flags (res_flags),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // fp32 <-> real for the small exact values used here
  function automatic logic [31:0] r2f(input real r);
    real m;
    int  e;
    logic s;
    if (r == 0.0) return '0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  // Datapath model
  logic [31:0] inner_q [INNER_LAT];
  logic [31:0] acc_q   [ACC_LAT];
  real         acc_sum = 0.0;
  real         acc_next;

  initial begin
    for (int i = 0; i < INNER_LAT; i++) inner_q[i] = '0;
    for (int i = 0; i < ACC_LAT; i++)   acc_q[i]   = '0;
  end

  assign acc_result = acc_q[ACC_LAT-1];

  always @(posedge clock) begin
    if (pipe_en) begin
      for (int i = INNER_LAT - 1; i > 0; i--) inner_q[i] <= inner_q[i-1];
      inner_q[0] <= pipe_dataa;
      acc_next = acc_n ? f2r(inner_q[INNER_LAT-1])
                       : acc_sum + f2r(inner_q[INNER_LAT-1]);
      acc_sum  <= acc_next;
      for (int i = ACC_LAT - 1; i > 0; i--) acc_q[i] <= acc_q[i-1];
      acc_q[0] <= r2f(acc_next);
    end
  end

  // Enabled-cycle monitors
  int          pe_cnt = 0;
  int          an_cnt = 0;
  logic [31:0] an_data = '0;

  always @(negedge clock) begin
    if (pipe_en) pe_cnt <= pe_cnt + 1;
    if (pipe_en && acc_n) begin
      an_cnt  <= an_cnt + 1;
      an_data <= inner_q[INNER_LAT-1];
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Batch driver state and observations
  logic [31:0] samples [8];
  int          acc_cyc, last_cyc, valid_cyc, fed_low, pe0, an0;
  logic [31:0] got_data;
  logic [1:0]  got_flags;

  task automatic run_batch(input int n, input int stall_at, input int stall_len,
                           input int hold, input logic xo, input logic xu);
    int i;
    int g;
    int stalls;
    logic [31:0] held;
    pe0 = pe_cnt;
    an0 = an_cnt;
    fed_low = 0;
    stalls = 0;
    acc_xo = xo;
    acc_xu = xu;
    cmd_valid = 1'b1;
    cmd_count = CNT_W'(n);
    g = 0;
    while (!cmd_ready && g < 20) begin step(); g++; end
    step();
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    i = 0;
    g = 0;
    last_cyc = acc_cyc;
    while (i < n && g < 300) begin
      if (i == stall_at && stalls < stall_len) begin
        in_valid = 1'b0;
        in_data  = '0;
        stalls++;
      end else begin
        in_valid = 1'b1;
        in_data  = samples[i];
      end
      #0;
      if (in_ready && !pipe_en) fed_low++;
      if (in_valid && in_ready) begin
        step();
        i++;
        if (i == n) last_cyc = cyc;
      end else begin
        step();
      end
      g++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    g = 0;
    while (!res_valid && g < 300) begin step(); g++; end
    valid_cyc = cyc;
    tests++;
    if (!res_valid) begin
      failed++;
      $display("FAIL res_valid_timeout: res_valid=%b, required 1", res_valid);
    end
    got_data  = res_data;
    got_flags = res_flags;
    acc_xo = 1'b0;
    acc_xu = 1'b0;
    held = res_data;
    for (int h = 0; h < hold; h++) begin
      step();
      tests++;
      if (res_valid !== 1'b1 || res_data !== held || cmd_ready !== 1'b0 || pipe_en !== 1'b0) begin
        failed++;
        $display("FAIL hold_stable: valid=%b data=%h cmd_ready=%b pipe_en=%b, required 1 %h 0 0",
                 res_valid, res_data, cmd_ready, pipe_en, held);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failed++;
      $display("FAIL release: valid=%b busy=%b cmd_ready=%b, required 0 0 1",
               res_valid, busy, cmd_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    tests++;
    if (res_valid !== 1'b0 || res_data !== 32'h0 || res_flags !== 2'b00 ||
        pipe_en !== 1'b0 || acc_n !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
        in_ready !== 1'b0) begin
      failed++;
      $display("FAIL %s: valid=%b data=%h flags=%b pipe_en=%b acc_n=%b busy=%b cmd_ready=%b in_ready=%b, required 0 0 0 0 0 0 1 0",
               name, res_valid, res_data, res_flags, pipe_en, acc_n, busy, cmd_ready, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    check_reset_values("reset_state");
    reset = 1'b0;
    step();
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_four_samples();
    samples[0] = 32'h3F800000; samples[1] = 32'h40000000;
    samples[2] = 32'h40400000; samples[3] = 32'h40800000;
    run_batch(4, -1, 0, 0, 1'b0, 1'b0);
    tests++;
    if (got_data !== 32'h41200000) begin failed++; $display("FAIL t1_data: got %h, required 41200000", got_data); end
    tests++;
    if (last_cyc - acc_cyc != 4) begin failed++; $display("FAIL t1_last_issue: got %0d, required 4", last_cyc - acc_cyc); end
    tests++;
    if (valid_cyc - acc_cyc != 55) begin failed++; $display("FAIL t1_latency: got %0d, required 55", valid_cyc - acc_cyc); end
    tests++;
    if (got_flags !== 2'b00) begin failed++; $display("FAIL t1_flags: got %b, required 00", got_flags); end
    tests++;
    if (an_cnt - an0 != 1 || an_data !== 32'h3F800000) begin
      failed++; $display("FAIL t1_acc_n: pulses=%0d aligned=%h, required 1 3f800000", an_cnt - an0, an_data);
    end
  endtask

  task automatic test_stall();
    samples[0] = 32'h3F800000; samples[1] = 32'h40000000;
    samples[2] = 32'h40400000; samples[3] = 32'h40800000;
    run_batch(4, 2, 5, 0, 1'b0, 1'b0);
    tests++;
    if (got_data !== 32'h41200000) begin failed++; $display("FAIL t2_data: got %h, required 41200000", got_data); end
    tests++;
    if (valid_cyc - acc_cyc != 60) begin failed++; $display("FAIL t2_latency: got %0d, required 60", valid_cyc - acc_cyc); end
    tests++;
    if (fed_low != 5) begin failed++; $display("FAIL t2_feed_stall: got %0d, required 5", fed_low); end
    tests++;
    if (an_cnt - an0 != 1) begin failed++; $display("FAIL t2_acc_n: got %0d, required 1", an_cnt - an0); end
  endtask

  task automatic test_empty_batch();
    run_batch(0, -1, 0, 0, 1'b0, 1'b0);
    tests++;
    if (valid_cyc != acc_cyc) begin failed++; $display("FAIL t3_latency: got %0d, required 0", valid_cyc - acc_cyc); end
    tests++;
    if (got_data !== 32'h0 || got_flags !== 2'b00) begin
      failed++; $display("FAIL t3_result: got %h/%b, required 0/00", got_data, got_flags);
    end
    tests++;
    if (pe_cnt != pe0) begin failed++; $display("FAIL t3_pipe_en: got %0d pulses, required 0", pe_cnt - pe0); end
  endtask

  task automatic test_single_sample();
    samples[0] = 32'h40200000;
    run_batch(1, -1, 0, 0, 1'b1, 1'b0);
    tests++;
    if (got_data !== 32'h40200000) begin failed++; $display("FAIL t4_data: got %h, required 40200000", got_data); end
    tests++;
    if (an_cnt - an0 != 1) begin failed++; $display("FAIL t4_acc_n: got %0d, required 1", an_cnt - an0); end
    tests++;
    if (valid_cyc - acc_cyc != 52) begin failed++; $display("FAIL t4_latency: got %0d, required 52", valid_cyc - acc_cyc); end
    tests++;
    if (got_flags !== 2'b10) begin failed++; $display("FAIL t4_flags: got %b, required 10", got_flags); end
  endtask

  task automatic test_back_to_back();
    samples[0] = 32'h3F800000; samples[1] = 32'h3F800000;
    run_batch(2, -1, 0, 10, 1'b0, 1'b0);
    tests++;
    if (got_data !== 32'h40000000) begin failed++; $display("FAIL t5_first: got %h, required 40000000", got_data); end
    samples[0] = 32'h40400000; samples[1] = 32'h40400000;
    run_batch(2, -1, 0, 0, 1'b0, 1'b0);
    tests++;
    if (got_data !== 32'h40C00000) begin failed++; $display("FAIL t5_second: got %h, required 40c00000", got_data); end
    tests++;
    if (got_flags !== 2'b00) begin failed++; $display("FAIL t5_flags_cleared: got %b, required 00", got_flags); end
  endtask

  task automatic test_reset_mid_drain();
    int g;
    cmd_valid = 1'b1;
    cmd_count = CNT_W'(2);
    step();
    cmd_valid = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h40E00000;
    g = 0;
    while (busy && in_ready !== 1'b0 && g < 10) begin step(); g++; end
    in_valid = 1'b0;
    in_data  = '0;
    repeat (10) step();
    tests++;
    if (busy !== 1'b1 || pipe_en !== 1'b1 || in_ready !== 1'b0) begin
      failed++; $display("FAIL t6_in_drain: busy=%b pipe_en=%b in_ready=%b, required 1 1 0", busy, pipe_en, in_ready);
    end
    reset = 1'b1;
    step();
    check_reset_values("t6_reset_values");
    reset = 1'b0;
    step();
    samples[0] = 32'h40A00000;
    run_batch(1, -1, 0, 0, 1'b0, 1'b1);
    tests++;
    if (got_data !== 32'h40A00000) begin failed++; $display("FAIL t6_data: got %h, required 40a00000", got_data); end
    tests++;
    if (got_flags !== 2'b01) begin failed++; $display("FAIL t6_flags: got %b, required 01", got_flags); end
  endtask

  initial begin
    test_reset();
    test_four_samples();
    step();
    test_stall();
    step();
    test_empty_batch();
    step();
    test_single_sample();
    step();
    test_back_to_back();
    step();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
